// File: rtl/cost_accumulator_if.sv
// Sample-in / cost-out bundle between the perceptron output stage and the cost accumulator.
interface cost_accumulator_if #(
  parameter int OUTPUT_SZ = 1,
  parameter int QN        = 6,
  parameter int QM        = 11,
  parameter int ERR_W     = 16
);
  localparam int BITWIDTH = QN + QM + 1;

  logic                            dataValid;
  logic [OUTPUT_SZ*BITWIDTH-1:0]   outputVec;
  logic [OUTPUT_SZ-1:0]            target;
  logic                            clearErr;
  logic                            busy;
  logic                            newCostFunc;
  logic [BITWIDTH-1:0]             costFunc;
  logic [ERR_W-1:0]                errCount;

  modport master (
    output dataValid, outputVec, target, clearErr,
    input  busy, newCostFunc, costFunc, errCount
  );

  modport slave (
    input  dataValid, outputVec, target, clearErr,
    output busy, newCostFunc, costFunc, errCount
  );
endinterface

// File: rtl/cost_accumulator.sv
// PLAN-sigmoid squared-error cost over OUTPUT_SZ channels and WINDOW samples, plus a bit-error count.
// Report lands OUTPUT_SZ+3 cycles after dataValid (WINDOW=1); dataValid while busy is dropped.
module cost_accumulator #(
  parameter int OUTPUT_SZ = 1,
  parameter int QN        = 6,
  parameter int QM        = 11,
  parameter int WINDOW    = 1,
  parameter int ERR_W     = 16
) (
  input logic               clock,
  input logic               reset,
  cost_accumulator_if.slave bus
);
  localparam int BITWIDTH = QN + QM + 1;
  localparam int CH_W     = (OUTPUT_SZ > 1) ? $clog2(OUTPUT_SZ) : 1;
  localparam int SMP_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int Y_W      = QM + 1;
  localparam int D_W      = QM + 2;

  localparam logic [BITWIDTH-1:0] A_FIVE  = BITWIDTH'(5 * 2**QM);
  localparam logic [BITWIDTH-1:0] A_2P375 = BITWIDTH'(19 * 2**(QM-3));
  localparam logic [BITWIDTH-1:0] A_ONE   = BITWIDTH'(2**QM);
  localparam logic [Y_W-1:0]      Y_ONE   = Y_W'(2**QM);
  localparam logic [Y_W-1:0]      Y_HALF  = Y_W'(2**(QM-1));
  localparam logic [Y_W-1:0]      C_HIGH  = Y_W'(27 * 2**(QM-5));
  localparam logic [Y_W-1:0]      C_MID   = Y_W'(5 * 2**(QM-3));

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} stateT;

  stateT                         state;
  logic [CH_W-1:0]               ch;
  logic [SMP_W-1:0]              sampleCnt;
  logic                          drainCnt;
  logic [OUTPUT_SZ*BITWIDTH-1:0] vecReg;
  logic [OUTPUT_SZ-1:0]          tgtReg;
  logic [BITWIDTH-1:0]           acc;

  logic signed [BITWIDTH-1:0]    xCur;
  logic [BITWIDTH-1:0]           aCur;
  logic [Y_W-1:0]                yMag;
  logic [Y_W-1:0]                yCur;
  logic                          tgtCur;

  logic                          s1Vld;
  logic [Y_W-1:0]                s1Y;
  logic                          s1Tgt;
  logic                          s2Vld;
  logic [Y_W-1:0]                s2Sq;

  logic signed [D_W-1:0]         dVal;
  logic signed [2*D_W-1:0]       prod;
  logic [Y_W-1:0]                sqVal;
  logic                          miss;
  logic [BITWIDTH:0]             accSum;
  logic [BITWIDTH-1:0]           accSat;

  // Negating the most negative code leaves 2^(BITWIDTH-1) unsigned, which lands in the a>=5 band.
  always_comb begin
    xCur   = $signed(vecReg[int'(ch)*BITWIDTH +: BITWIDTH]);
    tgtCur = tgtReg[ch];
    aCur   = xCur[BITWIDTH-1] ? BITWIDTH'(-xCur) : BITWIDTH'(xCur);
    if (aCur >= A_FIVE)
      yMag = Y_ONE;
    else if (aCur >= A_2P375)
      yMag = Y_W'(aCur >> 5) + C_HIGH;
    else if (aCur >= A_ONE)
      yMag = Y_W'(aCur >> 3) + C_MID;
    else
      yMag = Y_W'(aCur >> 2) + Y_HALF;
    yCur = xCur[BITWIDTH-1] ? (Y_ONE - yMag) : yMag;
  end

  always_comb begin
    dVal   = $signed({1'b0, s1Y}) - (s1Tgt ? $signed({1'b0, Y_ONE}) : $signed(D_W'(0)));
    prod   = dVal * dVal;
    sqVal  = Y_W'(prod >>> QM);
    miss   = (s1Y >= Y_HALF) != s1Tgt;
    accSum = {1'b0, acc} + (BITWIDTH+1)'(s2Sq);
    accSat = accSum[BITWIDTH] ? '1 : accSum[BITWIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= IDLE;
      ch              <= '0;
      sampleCnt       <= '0;
      drainCnt        <= 1'b0;
      vecReg          <= '0;
      tgtReg          <= '0;
      acc             <= '0;
      bus.busy        <= 1'b0;
      bus.newCostFunc <= 1'b0;
      bus.costFunc    <= '0;
    end else begin
      bus.newCostFunc <= 1'b0;
      if (s2Vld)
        acc <= accSat;
      case (state)
        IDLE: begin
          if (bus.dataValid) begin
            vecReg   <= bus.outputVec;
            tgtReg   <= bus.target;
            ch       <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (int'(ch) == OUTPUT_SZ - 1) begin
            drainCnt <= 1'b0;
            state    <= DRAIN;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        DRAIN: begin
          if (drainCnt) begin
            if (int'(sampleCnt) == WINDOW - 1) begin
              state <= REPORT;
            end else begin
              sampleCnt <= sampleCnt + 1'b1;
              bus.busy  <= 1'b0;
              state     <= IDLE;
            end
          end else begin
            drainCnt <= 1'b1;
          end
        end
        REPORT: begin
          bus.costFunc    <= acc;
          bus.newCostFunc <= 1'b1;
          acc             <= '0;
          sampleCnt       <= '0;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1Vld        <= 1'b0;
      s1Y          <= '0;
      s1Tgt        <= 1'b0;
      s2Vld        <= 1'b0;
      s2Sq         <= '0;
      bus.errCount <= '0;
    end else begin
      s1Vld <= (state == RUN);
      s1Y   <= yCur;
      s1Tgt <= tgtCur;
      s2Vld <= s1Vld;
      s2Sq  <= sqVal;
      if (bus.clearErr)
        bus.errCount <= '0;
      else if (s1Vld && miss && bus.errCount != {ERR_W{1'b1}})
        bus.errCount <= bus.errCount + 1'b1;
    end
  end
endmodule

// File: tb/tb_cost_accumulator.sv
// Directed bench: three parameterisations (per-sample, 8-sample window, 4 channels) of cost_accumulator.
module tb_cost_accumulator;
  localparam int BW = 18;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;
  int pulsesB = 0;

  cost_accumulator_if #(.OUTPUT_SZ(1), .ERR_W(3)) busA ();
  cost_accumulator_if #(.OUTPUT_SZ(1))            busB ();
  cost_accumulator_if #(.OUTPUT_SZ(4))            busC ();

  cost_accumulator #(.OUTPUT_SZ(1), .WINDOW(1), .ERR_W(3)) dutA (.clock(clock), .reset(reset), .bus(busA.slave));
  cost_accumulator #(.OUTPUT_SZ(1), .WINDOW(8))            dutB (.clock(clock), .reset(reset), .bus(busB.slave));
  cost_accumulator #(.OUTPUT_SZ(4), .WINDOW(1))            dutC (.clock(clock), .reset(reset), .bus(busC.slave));

  typedef struct {
    int   x;
    logic t;
    int   cost;
    int   err;
  } vecT;

  vecT vt[13];

  always @(negedge clock) if (busB.newCostFunc === 1'b1) pulsesB++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference sigmoid written from the band table with integer division.
  function automatic int modelY(input int x);
    int a;
    int y;
    a = (x < 0) ? -x : x;
    if (a >= 10240)     y = 2048;
    else if (a >= 4864) y = a / 32 + 1728;
    else if (a >= 2048) y = a / 8 + 1280;
    else                y = a / 4 + 1024;
    return (x < 0) ? 2048 - y : y;
  endfunction

  function automatic int modelSq(input int x, input int t);
    int d;
    d = modelY(x) - t * 2048;
    return (d * d) / 2048;
  endfunction

  task automatic runA(input int x, input logic t, output int lat);
    @(negedge clock);
    busA.outputVec = BW'(x);
    busA.target    = t;
    busA.dataValid = 1'b1;
    @(negedge clock);
    busA.dataValid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (busA.newCostFunc === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic runC(input logic [4*BW-1:0] vec, input logic [3:0] t, input int expCost,
                      input int expErr, input string tag);
    int lat;
    int model;
    model = 0;
    for (int c = 0; c < 4; c++) begin
      logic [BW-1:0] xs;
      xs = vec[c*BW +: BW];
      model += modelSq(int'($signed(xs)), int'(t[c]));
    end
    @(negedge clock);
    busC.outputVec = vec;
    busC.target    = t;
    busC.dataValid = 1'b1;
    @(negedge clock);
    busC.dataValid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (busC.newCostFunc === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, 7);
    check({tag, "_cost"}, busC.costFunc, expCost);
    check({tag, "_costModel"}, busC.costFunc, model);
    check({tag, "_err"}, busC.errCount, expErr);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    int p;

    vt[0]  = '{0,       1'b0, 512,  1};
    vt[1]  = '{10240,   1'b1, 0,    1};
    vt[2]  = '{-10240,  1'b1, 2048, 2};
    vt[3]  = '{-131072, 1'b1, 2048, 3};
    vt[4]  = '{2048,    1'b1, 128,  3};
    vt[5]  = '{-2048,   1'b0, 128,  3};
    vt[6]  = '{4864,    1'b1, 13,   3};
    vt[7]  = '{-4864,   1'b0, 13,   3};
    vt[8]  = '{1023,    1'b1, 288,  3};
    vt[9]  = '{-1,      1'b0, 512,  4};
    vt[10] = '{10239,   1'b1, 0,    4};
    vt[11] = '{-2049,   1'b0, 128,  4};
    vt[12] = '{4863,    1'b1, 12,   4};

    reset = 1'b0;
    busA.dataValid = 1'b0; busA.outputVec = '0; busA.target = '0; busA.clearErr = 1'b0;
    busB.dataValid = 1'b0; busB.outputVec = '0; busB.target = '0; busB.clearErr = 1'b0;
    busC.dataValid = 1'b0; busC.outputVec = '0; busC.target = '0; busC.clearErr = 1'b0;
    repeat (3) @(negedge clock);
    check("rstA_busy", busA.busy, 0);
    check("rstA_new", busA.newCostFunc, 0);
    check("rstA_cost", busA.costFunc, 0);
    check("rstA_err", busA.errCount, 0);
    check("rstB_busy", busB.busy, 0);
    check("rstB_cost", busB.costFunc, 0);
    check("rstC_busy", busC.busy, 0);
    check("rstC_err", busC.errCount, 0);
    reset = 1'b1;

    // Per-sample vectors on the single-channel instance.
    foreach (vt[i]) begin
      runA(vt[i].x, vt[i].t, lat);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_busy", i), busA.busy, 0);
      check($sformatf("vec%0d_cost", i), busA.costFunc, vt[i].cost);
      check($sformatf("vec%0d_err", i), busA.errCount, vt[i].err);
      @(negedge clock);
      check($sformatf("vec%0d_pulseEnd", i), busA.newCostFunc, 0);
    end

    // errCount (3 bits) climbs from 4 and sticks at 7.
    for (int i = 0; i < 5; i++) begin
      runA(0, 1'b0, lat);
      check($sformatf("sat%0d_err", i), busA.errCount, (4 + i + 1 > 7) ? 7 : 4 + i + 1);
    end

    // Eight-sample window with one dataValid pulsed while busy.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("win_noEarlyReport", pulsesB, 0);
      @(negedge clock);
      busB.outputVec = '0;
      busB.target    = 1'b1;
      busB.dataValid = 1'b1;
      @(negedge clock);
      busB.dataValid = 1'b0;
      if (i == 0) begin
        @(negedge clock);
        check("win_busyDuringRun", busB.busy, 1);
        busB.dataValid = 1'b1;
        @(negedge clock);
        busB.dataValid = 1'b0;
      end
      n = 0;
      while (busB.busy !== 1'b0 && n < 20) begin
        @(negedge clock);
        n++;
      end
      check($sformatf("win%0d_busyDrop", i), busB.busy, 0);
    end
    repeat (3) @(negedge clock);
    check("win_pulses", pulsesB, 1);
    check("win_cost", busB.costFunc, 4096);
    check("win_err", busB.errCount, 0);

    // Four channels: ch0..ch3 packed low to high.
    runC({BW'(0), BW'(4864), BW'(-2048), BW'(2048)}, 4'b1101, 781, 0, "ch4a");
    runC({BW'(10240), BW'(1023), BW'(0), BW'(-10240)}, 4'b0000, 3358, 3, "ch4b");

    // Reset while RUN aborts the sample.
    @(negedge clock);
    busA.outputVec = '0;
    busA.target    = 1'b0;
    busA.dataValid = 1'b1;
    @(negedge clock);
    busA.dataValid = 1'b0;
    check("midRst_busyBefore", busA.busy, 1);
    reset = 1'b0;
    @(negedge clock);
    check("midRst_busy", busA.busy, 0);
    check("midRst_new", busA.newCostFunc, 0);
    check("midRst_cost", busA.costFunc, 0);
    check("midRst_err", busA.errCount, 0);
    reset = 1'b1;
    p = 0;
    repeat (10) begin
      @(negedge clock);
      if (busA.newCostFunc === 1'b1) p++;
    end
    check("midRst_noPulse", p, 0);

    // clearErr lands on the same edge as a mismatch increment.
    @(negedge clock);
    busA.outputVec = '0;
    busA.target    = 1'b0;
    busA.dataValid = 1'b1;
    @(negedge clock);
    busA.dataValid = 1'b0;
    @(negedge clock);
    busA.clearErr = 1'b1;
    @(negedge clock);
    busA.clearErr = 1'b0;
    check("clrWins_err", busA.errCount, 0);
    n = 0;
    while (busA.newCostFunc !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("clrWins_report", busA.newCostFunc, 1);
    check("clrWins_cost", busA.costFunc, 512);
    check("clrWins_errAfter", busA.errCount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
